// File: rtl/oit_adder_arbiter_if.sv
// Request/response bundle between the client requesters and the shared adder arbiter.
// Requester i owns req[i] and the operand slices [i*WIDTH +: WIDTH].
interface oit_adder_arbiter_if #(
  parameter int COUNT = 4,
  parameter int WIDTH = 8
);
  logic [COUNT-1:0]       req;
  logic [COUNT*WIDTH-1:0] a_in;
  logic [COUNT*WIDTH-1:0] b_in;
  logic [COUNT-1:0]       grant;
  logic [COUNT-1:0]       done;
  logic [WIDTH:0]         sum;
  logic                   busy;

  modport master (
    output req, a_in, b_in,
    input  grant, done, sum, busy
  );

  modport slave (
    input  req, a_in, b_in,
    output grant, done, sum, busy
  );
endinterface

// File: rtl/oit_adder_arbiter.sv
// Round-robin arbiter that time-shares one oitAdder among COUNT requesters.
//
// state | meaning
// IDLE  | scan req from ptr upward, capture winner's operands
// EXEC  | shared adder evaluates captured operands, result loaded into sum
// RESP  | done pulse to winner, ptr advances past it
module oit_adder_arbiter #(
  parameter int COUNT = 4,
  parameter int WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  oit_adder_arbiter_if.slave  bus
);
  localparam int PW = $clog2(COUNT);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sum_q;
  logic [COUNT-1:0] grant_q;
  logic [COUNT-1:0] done_q;
  logic             busy_q;

  logic             sel_found;
  logic [PW-1:0]    sel_idx;
  logic [PW-1:0]    scan_idx;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [COUNT-1:0] grant_next;
  logic [PW-1:0]    ptr_next;

  // First asserted request at or above ptr, wrapping modulo COUNT.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < COUNT; k++) begin
      scan_idx = PW'((int'(ptr) + k) % COUNT);
      if (!sel_found && bus.req[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    a_sel      = '0;
    b_sel      = '0;
    grant_next = '0;
    for (int k = 0; k < COUNT; k++) begin
      if (sel_idx == PW'(k)) begin
        a_sel         = bus.a_in[k*WIDTH +: WIDTH];
        b_sel         = bus.b_in[k*WIDTH +: WIDTH];
        grant_next[k] = 1'b1;
      end
    end
  end

  assign ptr_next = (idx == PW'(COUNT - 1)) ? '0 : idx + 1'b1;

  oitAdder #(.A_WIDTH(WIDTH), .B_WIDTH(WIDTH)) u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      idx     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      sum_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            idx     <= sel_idx;
            op_a    <= a_sel;
            op_b    <= b_sel;
            grant_q <= grant_next;
            busy_q  <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          sum_q  <= add_sum;
          done_q <= grant_q;
          state  <= RESP;
        end
        RESP: begin
          done_q  <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr     <= ptr_next;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.busy  = busy_q;
endmodule

// Unsigned adder; result is one bit wider than the wider operand.
module oitAdder #(
  parameter  int A_WIDTH = 8,
  parameter  int B_WIDTH = 8,
  localparam int S_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1
) (
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [S_WIDTH-1:0] sum
);
  assign sum = S_WIDTH'(a) + S_WIDTH'(b);
endmodule

// File: tb/tb_oit_adder_arbiter.sv
// Scoreboard bench for oit_adder_arbiter: expected (requester, sum) pairs are queued
// as requests are raised and retired in order as done pulses appear.
module tb_oit_adder_arbiter;
  localparam int COUNT = 4;
  localparam int WIDTH = 8;

  typedef struct {
    int idx;
    int sum;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb[$];
  int   done_cyc[$];

  oit_adder_arbiter_if #(.COUNT(COUNT), .WIDTH(WIDTH)) bus ();

  oit_adder_arbiter #(.COUNT(COUNT), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requesters release req on the edge at which they see their done.
  task automatic tick();
    @(posedge clock);
    #1;
    bus.req = bus.req & ~bus.done;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    bus.a_in[i*WIDTH +: WIDTH] = WIDTH'(a);
    bus.b_in[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic expect_op(input int i, input int a, input int b);
    exp_t e;
    e.idx = i;
    e.sum = a + b;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 60 && sb.size() != 0; t++) tick();
    check_eq({tag, "_drain"}, 64'(sb.size()), 64'd0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      check_eq("grant_onehot", 64'($countones(bus.grant) <= 1), 64'd1);
      check_eq("done_onehot", 64'($countones(bus.done) <= 1), 64'd1);
      if (bus.done != '0) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("done_idx", 64'(bus.done), 64'(1) << e.idx);
          check_eq("sum", 64'(bus.sum), 64'(e.sum));
          check_eq("grant_hold", 64'(bus.grant), 64'(bus.done));
          check_eq("busy_resp", 64'(bus.busy), 64'd1);
          done_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;

    tick();
    tick();
    check_eq("rst_grant", 64'(bus.grant), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_sum", 64'(bus.sum), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    tick();

    // single request with latency checks
    set_op(0, 3, 5);
    expect_op(0, 3, 5);
    bus.req = 4'b0001;
    tick();
    check_eq("single_grant_n1", 64'(bus.grant), 64'b0001);
    check_eq("single_busy_n1", 64'(bus.busy), 64'd1);
    check_eq("single_done_n1", 64'(bus.done), 64'd0);
    tick();
    check_eq("single_grant_n2", 64'(bus.grant), 64'b0001);
    check_eq("single_done_n2", 64'(bus.done), 64'b0001);
    tick();
    check_eq("single_busy_after", 64'(bus.busy), 64'd0);
    check_eq("single_grant_after", 64'(bus.grant), 64'd0);
    check_eq("single_sum_hold", 64'(bus.sum), 64'd8);
    drain("single");

    // all requesting from reset
    do_reset();
    done_cyc.delete();
    for (int i = 0; i < COUNT; i++) begin
      set_op(i, i, 10);
      expect_op(i, i, 10);
    end
    bus.req = 4'b1111;
    drain("all");
    check_eq("all_count", 64'(done_cyc.size()), 64'd4);
    for (int k = 1; k < done_cyc.size(); k++)
      check_eq("done_gap", 64'(done_cyc[k] - done_cyc[k-1]), 64'd3);

    // fairness: serve 2, then 0 and 2 together; ptr=3 wraps so 0 goes first
    set_op(2, 7, 1);
    expect_op(2, 7, 1);
    bus.req = 4'b0100;
    drain("fair_pre");
    set_op(0, 20, 1);
    set_op(2, 30, 2);
    expect_op(0, 20, 1);
    expect_op(2, 30, 2);
    bus.req = 4'b0101;
    drain("fair");

    // carry-out
    set_op(1, 255, 255);
    expect_op(1, 255, 255);
    bus.req = 4'b0010;
    drain("carry_max");
    set_op(1, 255, 1);
    expect_op(1, 255, 1);
    bus.req = 4'b0010;
    drain("carry_256");

    // serve 0 so ptr=1, then reset during requester 1's EXEC
    set_op(0, 40, 2);
    expect_op(0, 40, 2);
    bus.req = 4'b0001;
    drain("pre_rst");
    set_op(1, 9, 9);
    bus.req = 4'b0010;
    tick();
    check_eq("midrst_grant_exec", 64'(bus.grant), 64'b0010);
    reset   = 1'b1;
    bus.req = '0;
    tick();
    check_eq("midrst_grant", 64'(bus.grant), 64'd0);
    check_eq("midrst_busy", 64'(bus.busy), 64'd0);
    check_eq("midrst_sum", 64'(bus.sum), 64'd0);
    check_eq("midrst_done", 64'(bus.done), 64'd0);
    reset = 1'b0;
    tick();
    tick();
    set_op(0, 1, 2);
    set_op(1, 4, 4);
    expect_op(0, 1, 2);
    expect_op(1, 4, 4);
    bus.req = 4'b0011;
    drain("post_rst");

    // early drop and operand change after capture
    set_op(3, 50, 60);
    expect_op(3, 50, 60);
    bus.req = 4'b1000;
    tick();
    check_eq("drop_grant_exec", 64'(bus.grant), 64'b1000);
    bus.req = '0;
    set_op(3, 1, 1);
    drain("early_drop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/oit_adder_arbiter.md
# oit_adder_arbiter

Round-robin arbiter and sequencer that shares one `oitAdder` instance among COUNT requesters. Each requester presents two operands and holds a request. The block grants one requester at a time, registers its operands, runs the shared adder, returns the registered sum and pulses a per-requester completion strobe. It sits between the adder datapath and the client blocks that previously each instantiated a private adder.

## Interface
Parameters:
- COUNT, 4, number of requesters; legal range 2..16.
- WIDTH, 8, operand width in bits; legal range 1..32.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
- req  in  COUNT  request per requester; bit i belongs to requester i.
- a_in  in  COUNT*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- b_in  in  COUNT*WIDTH  operand B; same packing as a_in.
- grant  out  COUNT  one-hot; identifies the requester being served; all zero when idle.
- done  out  COUNT  one-cycle completion pulse to the served requester.
- sum  out  WIDTH+1  registered result; MSB is carry-out.
- busy  out  1  high while an operation is in flight (EXEC or RESP).

## Operation
- FSM states: IDLE, EXEC, RESP. State is registered.
- **IDLE:**
  - If req is all zero, remain in IDLE.
  - Otherwise select the first asserted req bit, scanning upward from pointer `ptr` and wrapping modulo COUNT. Call it `idx`.
  - Latch a_in[idx] and b_in[idx] into operand registers. Set grant to one-hot `idx`. Go to EXEC.
- **EXEC:**
  - The operand registers drive the shared `oitAdder #(WIDTH, WIDTH)`.
  - Load its WIDTH+1-bit output into sum. Go to RESP.
- **RESP:**
  - Assert done[idx]; hold grant.
  - Set `ptr` = (idx+1) mod COUNT. Go to IDLE.
- **Pointer:**
  - `ptr` is oit.bits(COUNT) wide and resets to 0.
  - The requester just served has lowest priority for the next arbitration.
- **Arithmetic:**
  - Unsigned; sum = A + B, zero-extended to WIDTH+1 bits.
  - No overflow is possible.
- **Output holding:**
  - sum holds its value until the next RESP load.
  - sum is not cleared when returning to IDLE.
- **Handshake:**
  - A requester holds req and its operands stable until it samples done high.
  - It deasserts req on the same edge. Its req is therefore already low in the following IDLE cycle.
  - A req still high in that IDLE cycle is treated as a new request.
- **Operand changes:** operands are captured only in IDLE. Changes to a_in/b_in after capture do not affect the result.
- **req dropped early:** if a requester drops req after being granted, the operation still completes and done still pulses.
- **Requests during service:** req bits raised while in EXEC/RESP are not sampled until the next IDLE cycle.
- **Reset:**
  - At any time, including mid-operation, reset forces IDLE, ptr=0, grant=0, done=0, sum=0, busy=0.
  - An in-flight operation is dropped and its done never pulses.
- **Outputs:** grant, done and busy are decoded from registered state and index; they carry no combinational path from req.

## Timing
- Reset values: grant=0, done=0, sum=0, busy=0; state=IDLE; ptr=0.
- **Single-request latency**, with req seen in IDLE during cycle N:
  - grant and busy high in cycles N+1 and N+2.
  - sum valid from cycle N+2.
  - done high only in cycle N+2.
- **Throughput:**
  - One operation per 3 cycles under continuous demand.
  - Back-to-back service of different requesters: done pulses exactly 3 cycles apart.
- **Exclusivity:** at most one bit of grant, and at most one bit of done, high in any cycle.
- **Starvation bound:** a requester holding req is granted within COUNT arbitrations.

## Test plan
- **Single request:**
  - Stimulus: COUNT=4, WIDTH=8, req=0001, a=3, b=5.
  - Required: grant=0001 two cycles after the IDLE sample; done[0] pulses once; sum=8 in that cycle; busy=0 afterwards.
- **All requesting from reset:**
  - Stimulus: req=1111 held, each requester dropping on its own done; operands per requester i: a=i, b=10.
  - Required: service order 0,1,2,3; sums 10,11,12,13; done pulses 3 cycles apart.
- **Fairness:**
  - Stimulus: requester 2 served first; then req=0101 raised simultaneously.
  - Required: requester 0 is granted before requester 2, since ptr=3 wraps to 0.
- **Carry-out:**
  - Stimulus: a=255, b=255.
  - Required: sum=510 (9'h1FE); a=255, b=1 gives sum=256.
- **Reset mid-operation:**
  - Stimulus: reset asserted during EXEC for requester 1.
  - Required: next cycle grant=0, busy=0, sum=0, no done pulse; ptr=0, so a following req=0011 grants requester 0 first.
- **Early drop and operand change:**
  - Stimulus: requester 3 drops req and changes a_in during EXEC.
  - Required: done[3] still pulses; sum reflects the operands captured in IDLE.
